// File: rtl/pico_native_mem.sv
// Single-port word memory for the picorv32 native interface, with wait states, error responses, an MMIO output register and a backdoor preload port.
// Define PICO_MEM_TRACE_EN to print one line per completed transaction.
module pico_native_mem #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 1,
    parameter logic [31:0] MMIO_ADDR   = 32'h1000_0000,
    parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           mem_valid,
    input  logic                           mem_instr,
    input  logic [31:0]                    mem_addr,
    input  logic [31:0]                    mem_wdata,
    input  logic [3:0]                     mem_wstrb,
    output logic                           mem_ready,
    output logic [31:0]                    mem_rdata,
    output logic                           mem_err,
    output logic                           mmio_valid,
    output logic [31:0]                    mmio_data,
    input  logic                           init_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] init_addr,
    input  logic [31:0]                    init_data
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_MASK = ~(32'(DEPTH_WORDS * 4) - 32'd1);
    localparam logic [3:0]  LAT_M1    = 4'(LATENCY - 1);
    localparam bit          SINGLE    = (LATENCY == 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {K_MEM, K_MMIO, K_ERR} kind_t;

    state_t        state, next_state;
    logic [3:0]    cnt, next_cnt;
    logic          run;
    logic [31:0]   req_addr, req_wdata;
    logic [3:0]    req_wstrb;
    kind_t         req_kind;

    kind_t         in_kind_c, sel_kind_c;
    logic [31:0]   sel_addr_c, sel_wdata_c;
    logic [3:0]    sel_wstrb_c;
    logic [AW-1:0] sel_idx_c;
    logic          accept_c, commit_c, mem_wr_c;
    logic [31:0]   rdata_c, mmio_merge_c, wr_base_c;

    logic [31:0]   mem [DEPTH_WORDS];

    function automatic logic [31:0] merge_lanes(input logic [31:0] base,
                                                input logic [31:0] data,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = base;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
        end
        return res;
    endfunction

    // Address decode of the live request
    always_comb begin
        in_kind_c = K_ERR;
        if ((mem_addr & SPAN_MASK) == BASE_ADDR) begin
            in_kind_c = K_MEM;
        end else if (mem_addr[31:2] == MMIO_ADDR[31:2]) begin
            in_kind_c = K_MMIO;
        end
    end

    // A single-cycle latency commits straight from the bus; otherwise from the latched request
    always_comb begin
        if (state == S_IDLE) begin
            sel_addr_c  = mem_addr;
            sel_wdata_c = mem_wdata;
            sel_wstrb_c = mem_wstrb;
            sel_kind_c  = in_kind_c;
        end else begin
            sel_addr_c  = req_addr;
            sel_wdata_c = req_wdata;
            sel_wstrb_c = req_wstrb;
            sel_kind_c  = req_kind;
        end
        sel_idx_c = sel_addr_c[AW+1:2];
    end

    always_comb begin
        case (sel_kind_c)
            K_MEM:   rdata_c = mem[sel_idx_c];
            K_MMIO:  rdata_c = mmio_data;
            default: rdata_c = ERR_RDATA;
        endcase
        mmio_merge_c = merge_lanes(mmio_data, sel_wdata_c, sel_wstrb_c);
        mem_wr_c     = commit_c && (sel_kind_c == K_MEM) && (sel_wstrb_c != 4'd0);
        // Lanes not written by the bus take a same-cycle backdoor value
        wr_base_c    = (init_we && (init_addr == sel_idx_c)) ? init_data : mem[sel_idx_c];
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        accept_c   = 1'b0;
        commit_c   = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_valid && run) begin
                    accept_c = 1'b1;
                    if (SINGLE) begin
                        next_state = S_RESP;
                        commit_c   = 1'b1;
                    end else begin
                        next_state = S_WAIT;
                        next_cnt   = LAT_M1;
                    end
                end
            end
            S_WAIT: begin
                if (!mem_valid) begin
                    next_state = S_IDLE;
                    next_cnt   = 4'd0;
                end else if (cnt == 4'd1) begin
                    next_state = S_RESP;
                    next_cnt   = 4'd0;
                    commit_c   = 1'b1;
                end else begin
                    next_cnt = cnt - 4'd1;
                end
            end
            S_RESP: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
                next_cnt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            run   <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            run   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_addr  <= 32'd0;
            req_wdata <= 32'd0;
            req_wstrb <= 4'd0;
            req_kind  <= K_ERR;
        end else if (accept_c) begin
            req_addr  <= mem_addr;
            req_wdata <= mem_wdata;
            req_wstrb <= mem_wstrb;
            req_kind  <= in_kind_c;
        end
    end

    // Response registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_ready  <= 1'b0;
            mem_err    <= 1'b0;
            mem_rdata  <= 32'd0;
            mmio_valid <= 1'b0;
            mmio_data  <= 32'd0;
        end else begin
            mem_ready  <= commit_c;
            mem_err    <= commit_c && (sel_kind_c == K_ERR);
            mmio_valid <= commit_c && (sel_kind_c == K_MMIO) && (sel_wstrb_c != 4'd0);
            if (commit_c) begin
                mem_rdata <= rdata_c;
                if ((sel_kind_c == K_MMIO) && (sel_wstrb_c != 4'd0)) begin
                    mmio_data <= mmio_merge_c;
                end
            end
        end
    end

    // Storage array; contents survive reset
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_addr] <= init_data;
        end
        if (mem_wr_c) begin
            mem[sel_idx_c] <= merge_lanes(wr_base_c, sel_wdata_c, sel_wstrb_c);
        end
    end

`ifdef PICO_MEM_TRACE_EN
    logic req_instr;
    logic sel_instr_c;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_instr <= 1'b0;
        end else if (accept_c) begin
            req_instr <= mem_instr;
        end
    end

    assign sel_instr_c = (state == S_IDLE) ? mem_instr : req_instr;

    always_ff @(posedge clk) begin
        if (commit_c) begin
            if (sel_kind_c == K_ERR)
                $display("pico_mem err    addr=%08h data=%08h", sel_addr_c, ERR_RDATA);
            else if (sel_kind_c == K_MMIO)
                $display("pico_mem mmio   addr=%08h data=%08h wstrb=%b", sel_addr_c,
                         (sel_wstrb_c != 4'd0) ? sel_wdata_c : mmio_data, sel_wstrb_c);
            else if (sel_wstrb_c != 4'd0)
                $display("pico_mem write  addr=%08h data=%08h wstrb=%b", sel_addr_c, sel_wdata_c, sel_wstrb_c);
            else if (sel_instr_c)
                $display("pico_mem ifetch addr=%08h data=%08h", sel_addr_c, rdata_c);
            else
                $display("pico_mem read   addr=%08h data=%08h", sel_addr_c, rdata_c);
        end
    end
`else
    logic unused_instr;
    assign unused_instr = mem_instr;
`endif

endmodule

// File: tb/tb_pico_native_mem.sv
// Randomized bench for pico_native_mem: three instances at LATENCY 1, 4 and 8 checked against an array-based model.
module tb_pico_native_mem;

    localparam logic [31:0] MMIO = 32'h1000_0000;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    logic [2:0]       valid, instr, ready, err, mv, init_we;
    logic [2:0][31:0] addr, wdata, rdata, md, init_data;
    logic [2:0][3:0]  wstrb;
    logic [2:0][7:0]  init_addr;

    logic [31:0] model [3][256];
    logic [31:0] mmio_m [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pico_native_mem #(
            .DEPTH_WORDS(256),
            .BASE_ADDR  (32'h0000_0000),
            .LATENCY    (g == 0 ? 1 : (g == 1 ? 4 : 8)),
            .MMIO_ADDR  (MMIO),
            .ERR_RDATA  (ERRD)
        ) dut (
            .clk       (clk),
            .resetn    (resetn),
            .mem_valid (valid[g]),
            .mem_instr (instr[g]),
            .mem_addr  (addr[g]),
            .mem_wdata (wdata[g]),
            .mem_wstrb (wstrb[g]),
            .mem_ready (ready[g]),
            .mem_rdata (rdata[g]),
            .mem_err   (err[g]),
            .mmio_valid(mv[g]),
            .mmio_data (md[g]),
            .init_we   (init_we[g]),
            .init_addr (init_addr[g]),
            .init_data (init_data[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 4 : 8);
    endfunction

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic chk_idle(input int k, input string tag);
        check($sformatf("%s_d%0d_ready", tag, k), 32'(ready[k]), 32'd0);
        check($sformatf("%s_d%0d_err", tag, k), 32'(err[k]), 32'd0);
        check($sformatf("%s_d%0d_rdata", tag, k), rdata[k], 32'd0);
        check($sformatf("%s_d%0d_mv", tag, k), 32'(mv[k]), 32'd0);
        check($sformatf("%s_d%0d_md", tag, k), md[k], 32'd0);
    endtask

    task automatic bd_write(input int k, input int unsigned i, input logic [31:0] d);
        init_we[k] = 1'b1;
        init_addr[k] = 8'(i);
        init_data[k] = d;
        @(negedge clk);
        init_we[k] = 1'b0;
        model[k][i] = d;
    endtask

    // One bus transaction; called at a negedge. held: previous request left valid high.
    task automatic do_txn(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic ins, input bit held, input bit keep,
                          input bit bd_en, input int unsigned bd_a, input logic [31:0] bd_d);
        int exp_n, n, kind;
        int unsigned idx;
        bit got;
        logic [31:0] exp_rd;
        exp_n = lat_of(k) + (held ? 1 : 0);
        idx = (a >> 2) % 256;
        if (a < 32'd1024) kind = 0;
        else if ((a >> 2) == (MMIO >> 2)) kind = 1;
        else kind = 2;
        exp_rd = (kind == 0) ? model[k][idx] : ((kind == 1) ? mmio_m[k] : ERRD);

        valid[k] = 1'b1;
        addr[k] = a;
        wdata[k] = d;
        wstrb[k] = s;
        instr[k] = ins;
        if (bd_en && exp_n == 1) begin
            init_we[k] = 1'b1; init_addr[k] = 8'(bd_a); init_data[k] = bd_d;
        end
        got = 1'b0;
        n = 0;
        for (int c = 1; c <= exp_n + 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            n = c;
            init_we[k] = 1'b0;
            if (ready[k]) begin
                got = 1'b1;
                break;
            end
            if (bd_en && c == exp_n - 1) begin
                init_we[k] = 1'b1; init_addr[k] = 8'(bd_a); init_data[k] = bd_d;
            end
        end
        check($sformatf("d%0d_ready_seen", k), 32'(got), 32'd1);
        check($sformatf("d%0d_latency", k), 32'(n), 32'(exp_n));

        if (bd_en) model[k][bd_a] = bd_d;
        if (kind == 0 && s != 4'd0) model[k][idx] = lanes(model[k][idx], d, s);
        if (kind == 1 && s != 4'd0) mmio_m[k] = lanes(mmio_m[k], d, s);

        if (got) begin
            if (!(kind == 1 && s != 4'd0))
                check($sformatf("d%0d_rdata_a%08h", k, a), rdata[k], exp_rd);
            check($sformatf("d%0d_err", k), 32'(err[k]), 32'(kind == 2));
            check($sformatf("d%0d_mmio_valid", k), 32'(mv[k]), 32'(kind == 1 && s != 4'd0));
            check($sformatf("d%0d_mmio_data", k), md[k], mmio_m[k]);
        end
        if (!keep) begin
            valid[k] = 1'b0;
            wstrb[k] = 4'd0;
            @(negedge clk);
            check($sformatf("d%0d_ready_pulse", k), 32'(ready[k]), 32'd0);
            check($sformatf("d%0d_mv_pulse", k), 32'(mv[k]), 32'd0);
        end
    endtask

    initial begin
        int cnt;
        bit prev_keep, keep, bd_en;
        logic [31:0] a;
        logic [3:0] s;
        int unsigned bd_a, r;

        valid = '0; instr = '0; addr = '0; wdata = '0; wstrb = '0;
        init_we = '0; init_addr = '0; init_data = '0;
        for (int k = 0; k < 3; k++) mmio_m[k] = 32'd0;

        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) chk_idle(k, "reset");
        resetn = 1'b1;
        @(negedge clk);

        // Preload every word of every instance
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 3; k++) begin
                init_we[k] = 1'b1;
                init_addr[k] = 8'(i);
                init_data[k] = $urandom;
                model[k][i] = init_data[k];
            end
            @(negedge clk);
        end
        init_we = '0;

        // Instruction fetch at single-cycle latency
        bd_write(0, 0, 32'h3bc00093);
        do_txn(0, 32'h0, 32'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0);

        // Partial write then read with wait states
        bd_write(1, 8, 32'h0);
        do_txn(1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
        do_txn(1, 32'h20, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
        check("d1_partial_const", rdata[1], 32'h00BB00DD);

        // Unmapped read and write; the aliasing word must stay intact
        do_txn(0, 32'h400, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
        do_txn(0, 32'h400, 32'h12345678, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
        do_txn(0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);

        // MMIO byte write
        do_txn(0, MMIO, 32'h0000_0041, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
        check("d0_mmio_const", md[0], 32'h41);

        // Abort: valid drops during the wait phase
        valid[1] = 1'b1; addr[1] = 32'hC; wdata[1] = ~model[1][3]; wstrb[1] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        valid[1] = 1'b0; wstrb[1] = 4'd0;
        cnt = 0;
        repeat (8) begin @(negedge clk); if (ready[1]) cnt++; end
        check("d1_abort_ready", 32'(cnt), 32'd0);
        do_txn(1, 32'hC, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);

        // Reset two cycles into a LATENCY=8 write
        valid[2] = 1'b1; addr[2] = 32'h10; wdata[2] = ~model[2][4]; wstrb[2] = 4'hF;
        @(posedge clk);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk_idle(k, "midreset");
        for (int k = 0; k < 3; k++) mmio_m[k] = 32'd0;
        cnt = 0;
        repeat (4) begin @(negedge clk); if (ready[2]) cnt++; end
        valid[2] = 1'b0; wstrb[2] = 4'd0;
        resetn = 1'b1;
        repeat (10) begin @(negedge clk); if (ready[2]) cnt++; end
        check("d2_reset_no_ready", 32'(cnt), 32'd0);
        do_txn(2, 32'h10, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);

        // Randomized traffic, with held-valid streams and backdoor collisions
        for (int k = 0; k < 3; k++) begin
            prev_keep = 1'b0;
            for (int i = 0; i < 40; i++) begin
                r = $urandom_range(0, 9);
                if (r <= 5) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
                else if (r <= 7) a = MMIO + 32'($urandom_range(0, 3));
                else if (r == 8) a = 32'h400 + 32'($urandom_range(0, 255) * 4);
                else a = 32'h2000_0000;
                s = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                bd_en = ($urandom_range(0, 3) == 0);
                bd_a = ($urandom_range(0, 1) == 0) ? ((a >> 2) % 256) : $urandom_range(0, 15);
                keep = (i < 39) && ($urandom_range(0, 1) == 1);
                do_txn(k, a, $urandom, s, 1'($urandom_range(0, 1)), prev_keep, keep, bd_en, bd_a, $urandom);
                prev_keep = keep;
            end
            // Read back the active region
            for (int w = 0; w < 16; w++)
                do_txn(k, 32'(w * 4), 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
